pueo_mode1_cmdproc: RTL and testbench

//  Consumes the mode1 byte stream (tdata/tvalid/tlast, no backpressure) from the command decoder.

---
 rtl/pueo_mode1_pkg.sv | 20 ++
 rtl/pueo_mode1_cmdproc_if.sv | 23 ++
 rtl/pueo_sat_counter.sv | 29 ++
 rtl/pueo_mode1_cmdproc.sv | 177 +++++++++++++++++
 tb/tb_pueo_mode1_cmdproc.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pueo_mode1_pkg.sv
// Shared constants, error flag bit positions and FSM state type for the mode1 command processor.
package pueo_mode1_pkg;

   localparam logic [7:0] MODE1_OP_WRITE = 8'h01;
   localparam int         MODE1_PKT_LEN  = 8;
   localparam logic [2:0] MODE1_LAST_IDX = 3'(MODE1_PKT_LEN - 1);

   localparam int ERR_FRAMING  = 0;
   localparam int ERR_CHECKSUM = 1;
   localparam int ERR_OVERRUN  = 2;
   localparam int ERR_TIMEOUT  = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DISCARD = 2'd2,
      ST_WRITE   = 2'd3
   } mode1_state_t;

endpackage

// File: rtl/pueo_mode1_cmdproc_if.sv
// Mode1 byte stream in and SURF register-write bus out, bundled for the command processor.
interface pueo_mode1_cmdproc_if #(
   parameter int ADDR_BITS = 16
);
   logic [7:0]           s_tdata;
   logic                 s_tvalid;
   logic                 s_tlast;
   logic                 s_tready;
   logic                 reg_wr_o;
   logic [ADDR_BITS-1:0] reg_addr_o;
   logic [31:0]          reg_wdata_o;
   logic                 reg_ack_i;

   modport slave (
      input  s_tdata, s_tvalid, s_tlast, reg_ack_i,
      output s_tready, reg_wr_o, reg_addr_o, reg_wdata_o
   );

   modport master (
      output s_tdata, s_tvalid, s_tlast, reg_ack_i,
      input  s_tready, reg_wr_o, reg_addr_o, reg_wdata_o
   );
endinterface

// File: rtl/pueo_sat_counter.sv
// Saturating up-counter with async reset and synchronous clear (clear wins over increment).
module pueo_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count_o
);
   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (inc && (count_q != '1))
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count_o = count_q;
endmodule

// File: rtl/pueo_mode1_cmdproc.sv
// Frames 8-byte mode1 packets, verifies checksum/opcode and issues one register write per good packet.
module pueo_mode1_cmdproc
   import pueo_mode1_pkg::*;
#(
   parameter int ADDR_BITS   = 16,
   parameter int ACK_TIMEOUT = 255,
   parameter     DEBUG       = "TRUE"
) (
   input  logic                 sysclk_i,
   input  logic                 rst_i,
   input  logic                 cmdproc_rst_i,
   pueo_mode1_cmdproc_if.slave  bus,
   output logic [15:0]          pkt_count_o,
   output logic [15:0]          err_count_o,
   output logic [3:0]           err_flags_o,
   output logic [1:0]           state_o
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   mode1_state_t         state_q, state_d;
   logic [2:0]           idx_q, idx_d;
   logic [7:0]           sum_q, sum_d, sum_total;
   logic [7:0]           pkt_byte [0:MODE1_PKT_LEN-2];
   logic [15:0]          addr_full;
   logic                 byte_v, pkt_end, pkt_ok, launch, wr_done, err_any;
   logic [3:0]           err_vec;
   logic                 wr_q, wr_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [3:0]           flags_q, flags_d;

   // Soft reset takes priority, so a byte landing in the same cycle is lost.
   assign byte_v = bus.s_tvalid && !cmdproc_rst_i;

   always_ff @(posedge sysclk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      if (cmdproc_rst_i) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         sum_d   = '0;
      end else if (bus.s_tvalid) begin
         case (state_q)
            ST_IDLE: begin
               if (!bus.s_tlast) begin
                  state_d = ST_COLLECT;
                  idx_d   = 3'd1;
                  sum_d   = bus.s_tdata;
               end
            end
            ST_COLLECT: begin
               if (bus.s_tlast || (idx_q == MODE1_LAST_IDX)) begin
                  state_d = bus.s_tlast ? ST_IDLE : ST_DISCARD;
                  idx_d   = '0;
                  sum_d   = '0;
               end else begin
                  idx_d = idx_q + 3'd1;
                  sum_d = sum_q + bus.s_tdata;
               end
            end
            ST_DISCARD: begin
               if (bus.s_tlast)
                  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      sum_total = sum_q + bus.s_tdata;
      pkt_end   = byte_v && (state_q == ST_COLLECT) && (idx_q == MODE1_LAST_IDX) && bus.s_tlast;
      pkt_ok    = pkt_end && (sum_total == 8'h00) && (pkt_byte[0] == MODE1_OP_WRITE);
      launch    = pkt_ok && !wr_q;
      wr_done   = wr_q && bus.reg_ack_i && !cmdproc_rst_i;
      err_vec   = '0;
      err_vec[ERR_FRAMING]  = byte_v &&
                              (((state_q == ST_IDLE) && bus.s_tlast) ||
                               ((state_q == ST_COLLECT) && (bus.s_tlast ^ (idx_q == MODE1_LAST_IDX))));
      err_vec[ERR_CHECKSUM] = pkt_end && (sum_total != 8'h00);
      err_vec[ERR_OVERRUN]  = pkt_ok && wr_q;
      err_vec[ERR_TIMEOUT]  = wr_q && !bus.reg_ack_i && !cmdproc_rst_i &&
                              (timer_q == TW'(ACK_TIMEOUT - 1));
      err_any   = |err_vec;
   end

   generate
      for (genvar gi = 0; gi < MODE1_PKT_LEN - 1; gi++) begin : g_byte
         logic [7:0] b_q;
         always_ff @(posedge sysclk_i) begin
            if (byte_v && (state_q != ST_DISCARD) && (idx_q == 3'(gi)))
               b_q <= bus.s_tdata;
         end
         assign pkt_byte[gi] = b_q;
      end
   endgenerate

   assign addr_full = {pkt_byte[1], pkt_byte[2]};

   // The write side runs independently so the collector can frame the next packet meanwhile.
   always_comb begin
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      timer_d = timer_q;
      flags_d = flags_q | err_vec;
      if (cmdproc_rst_i) begin
         wr_d    = 1'b0;
         addr_d  = '0;
         wdata_d = '0;
         timer_d = '0;
         flags_d = '0;
      end else if (launch) begin
         wr_d    = 1'b1;
         addr_d  = addr_full[ADDR_BITS-1:0];
         wdata_d = {pkt_byte[3], pkt_byte[4], pkt_byte[5], pkt_byte[6]};
         timer_d = '0;
      end else if (wr_q) begin
         if (bus.reg_ack_i || err_vec[ERR_TIMEOUT])
            wr_d = 1'b0;
         else
            timer_d = timer_q + 1'b1;
      end
   end

   always_ff @(posedge sysclk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         timer_q <= '0;
         flags_q <= '0;
      end else begin
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         timer_q <= timer_d;
         flags_q <= flags_d;
      end
   end

   pueo_sat_counter #(.WIDTH(16)) u_pkt_cnt (
      .clk(sysclk_i), .rst(rst_i), .clr(cmdproc_rst_i), .inc(wr_done), .count_o(pkt_count_o)
   );

   pueo_sat_counter #(.WIDTH(16)) u_err_cnt (
      .clk(sysclk_i), .rst(rst_i), .clr(cmdproc_rst_i), .inc(err_any), .count_o(err_count_o)
   );

   generate
      if (DEBUG == "TRUE") begin : g_dbg
         assign state_o = ((state_q == ST_IDLE) && wr_q) ? ST_WRITE : state_q;
      end else begin : g_nodbg
         assign state_o = 2'd0;
      end
   endgenerate

   assign bus.s_tready    = 1'b1;
   assign bus.reg_wr_o    = wr_q;
   assign bus.reg_addr_o  = addr_q;
   assign bus.reg_wdata_o = wdata_q;
   assign err_flags_o     = flags_q;
endmodule

// File: tb/tb_pueo_mode1_cmdproc.sv
// Table-driven packet vectors plus multi-cycle sequences; expected writes go through a scoreboard queue.
module tb_pueo_mode1_cmdproc;
   import pueo_mode1_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        crst = 1'b0;
   logic [15:0] pkt_cnt, err_cnt;
   logic [3:0]  flags;
   logic [1:0]  st;

   always #4 clk = ~clk;

   pueo_mode1_cmdproc_if #(.ADDR_BITS(16)) bus ();

   pueo_mode1_cmdproc #(.ADDR_BITS(16), .ACK_TIMEOUT(255), .DEBUG("TRUE")) dut (
      .sysclk_i(clk), .rst_i(rst), .cmdproc_rst_i(crst), .bus(bus.slave),
      .pkt_count_o(pkt_cnt), .err_count_o(err_cnt), .err_flags_o(flags), .state_o(st)
   );

   typedef struct {
      logic [71:0] raw;
      int          nbytes;
      int          ack_dly;
      bit          exp_wr;
      logic [15:0] exp_addr;
      logic [31:0] exp_data;
      logic [3:0]  exp_flags;
      logic [15:0] exp_err;
      logic [15:0] exp_pkt;
   } vec_t;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   vec_t vecs[9];
   wr_t  sb[$];
   int   checks = 0;
   int   passes = 0;
   int   ack_dly = -1;
   int   high_cnt = 0;
   int   last_high = 0;
   int   rises = 0;

   // Bytes B0..B6 given big-endian; appends the two's-complement checksum as B7.
   function automatic logic [71:0] good(input logic [55:0] b);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < 7; i++) s = s + b[55-8*i -: 8];
      return {b, 8'h00 - s, 8'h00};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      @(negedge clk);
      bus.s_tdata  = d;
      bus.s_tvalid = 1'b1;
      bus.s_tlast  = last;
      @(negedge clk);
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [71:0] raw, input int n);
      for (int i = 0; i < n; i++) send_byte(raw[71-8*i -: 8], (i == n - 1));
   endtask

   task automatic soft_reset();
      @(negedge clk);
      crst = 1'b1;
      @(negedge clk);
      crst = 1'b0;
   endtask

   task automatic check_status(input string tag, input logic [3:0] f, input logic [15:0] e,
                               input logic [15:0] p);
      check({tag, "_flags"}, 32'(flags), 32'(f));
      check({tag, "_err"}, 32'(err_cnt), 32'(e));
      check({tag, "_pkt"}, 32'(pkt_cnt), 32'(p));
      check({tag, "_state"}, 32'(st), 32'(ST_IDLE));
   endtask

   // Write-bus responder and scoreboard consumer.
   initial begin
      wr_t cur;
      bit  have;
      have = 1'b0;
      cur  = '{addr: 16'h0, data: 32'h0};
      bus.reg_ack_i = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.reg_wr_o) begin
            high_cnt++;
            if (high_cnt == 1) begin
               rises++;
               if (sb.size() == 0) begin
                  checks++;
                  have = 1'b0;
                  $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                           bus.reg_addr_o, bus.reg_wdata_o);
               end else begin
                  cur  = sb.pop_front();
                  have = 1'b1;
                  check("wr_addr", 32'(bus.reg_addr_o), 32'(cur.addr));
                  check("wr_data", bus.reg_wdata_o, cur.data);
               end
            end else if (have && (high_cnt <= 8)) begin
               check("wr_addr_stable", 32'(bus.reg_addr_o), 32'(cur.addr));
               check("wr_data_stable", bus.reg_wdata_o, cur.data);
            end
            bus.reg_ack_i = (ack_dly >= 0) && (high_cnt == ack_dly + 1);
         end else begin
            if (high_cnt != 0) last_high = high_cnt;
            high_cnt      = 0;
            bus.reg_ack_i = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 2 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int t;
      bus.s_tdata  = 8'h00;
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_wr", 32'(bus.reg_wr_o), 32'd0);
      check("rst_addr", 32'(bus.reg_addr_o), 32'd0);
      check("rst_wdata", bus.reg_wdata_o, 32'd0);
      check_status("rst", 4'b0000, 16'd0, 16'd0);
      rst = 1'b0;

      vecs[0] = '{good(56'h01_0010_DEADBEEF), 8, 3, 1'b1, 16'h0010, 32'hDEADBEEF, 4'b0000, 16'd0, 16'd1};
      vecs[1] = '{good(56'h01_0010_DEADBEEF) ^ 72'h100, 8, 3, 1'b0, 16'h0, 32'h0, 4'b0010, 16'd1, 16'd0};
      vecs[2] = '{good(56'h02_0010_DEADBEEF), 8, 3, 1'b0, 16'h0, 32'h0, 4'b0000, 16'd0, 16'd0};
      vecs[3] = '{good(56'h01_1234_01020304), 8, 0, 1'b1, 16'h1234, 32'h01020304, 4'b0000, 16'd0, 16'd1};
      vecs[4] = '{good(56'h01_0010_DEADBEEF), 4, 3, 1'b0, 16'h0, 32'h0, 4'b0001, 16'd1, 16'd0};
      vecs[5] = '{72'h01_0010_DEADBEEF_55_66, 9, 3, 1'b0, 16'h0, 32'h0, 4'b0001, 16'd1, 16'd0};
      vecs[6] = '{good(56'h01_0010_DEADBEEF), 1, 3, 1'b0, 16'h0, 32'h0, 4'b0001, 16'd1, 16'd0};
      vecs[7] = '{good(56'h01_ABCD_CAFEF00D), 8, 7, 1'b1, 16'hABCD, 32'hCAFEF00D, 4'b0000, 16'd0, 16'd1};
      vecs[8] = '{good(56'h01_0010_DEADBEEF), 7, 3, 1'b0, 16'h0, 32'h0, 4'b0001, 16'd1, 16'd0};

      foreach (vecs[v]) begin
         soft_reset();
         ack_dly   = vecs[v].ack_dly;
         last_high = 0;
         r0        = rises;
         if (vecs[v].exp_wr) sb.push_back('{addr: vecs[v].exp_addr, data: vecs[v].exp_data});
         send_pkt(vecs[v].raw, vecs[v].nbytes);
         repeat (16) @(negedge clk);
         check_status($sformatf("vec%0d", v), vecs[v].exp_flags, vecs[v].exp_err, vecs[v].exp_pkt);
         check($sformatf("vec%0d_writes", v), 32'(rises - r0), 32'(vecs[v].exp_wr));
         if (vecs[v].exp_wr)
            check($sformatf("vec%0d_wr_len", v), 32'(last_high), 32'(vecs[v].ack_dly + 1));
         $display("vec %0d: bytes=%0d flags=%b err=%0d pkt=%0d wr_len=%0d",
                  v, vecs[v].nbytes, flags, err_cnt, pkt_cnt, last_high);
      end

      // Short packet, then a good packet that must still be written.
      soft_reset();
      ack_dly = 2;
      send_pkt(good(56'h01_0010_DEADBEEF), 4);
      sb.push_back('{addr: 16'h0020, data: 32'h11223344});
      send_pkt(good(56'h01_0020_11223344), 8);
      repeat (16) @(negedge clk);
      check_status("frame_then_good", 4'b0001, 16'd1, 16'd1);
      check("frame_then_good_len", 32'(last_high), 32'd3);
      $display("seq frame_then_good: flags=%b err=%0d pkt=%0d", flags, err_cnt, pkt_cnt);

      // Unacknowledged write, second packet overruns, first write times out.
      soft_reset();
      ack_dly   = -1;
      last_high = 0;
      sb.push_back('{addr: 16'h0010, data: 32'hDEADBEEF});
      send_pkt(good(56'h01_0010_DEADBEEF), 8);
      send_pkt(good(56'h01_0030_55667788), 8);
      check("overrun_flags", 32'(flags), 32'b0100);
      check("overrun_err", 32'(err_cnt), 32'd1);
      check("overrun_wr_held", 32'(bus.reg_wr_o), 32'd1);
      t = 0;
      while (bus.reg_wr_o && (t < 400)) begin
         @(negedge clk);
         t++;
      end
      check("timeout_fall", 32'(bus.reg_wr_o), 32'd0);
      @(negedge clk);
      check("timeout_len", 32'(last_high), 32'd255);
      check_status("timeout", 4'b1100, 16'd2, 16'd0);
      $display("seq overrun_timeout: flags=%b err=%0d pkt=%0d wr_len=%0d", flags, err_cnt, pkt_cnt, last_high);

      // Soft reset mid-packet and soft reset colliding with a byte strobe.
      soft_reset();
      ack_dly = 1;
      sb.push_back('{addr: 16'h0040, data: 32'h0BADF00D});
      send_pkt(good(56'h01_0040_0BADF00D), 8);
      send_pkt(good(56'h01_0040_0BADF00D) ^ 72'h100, 8);
      repeat (10) @(negedge clk);
      check("pre_crst_pkt", 32'(pkt_cnt), 32'd1);
      check("pre_crst_err", 32'(err_cnt), 32'd1);
      send_pkt(good(56'h01_0050_12345678), 4);
      soft_reset();
      check_status("crst_mid", 4'b0000, 16'd0, 16'd0);
      @(negedge clk);
      crst = 1'b1;
      bus.s_tdata  = 8'h01;
      bus.s_tvalid = 1'b1;
      @(negedge clk);
      crst = 1'b0;
      bus.s_tvalid = 1'b0;
      check("crst_drop_state", 32'(st), 32'(ST_IDLE));
      sb.push_back('{addr: 16'h0060, data: 32'hA5A5_5A5A});
      send_pkt(good(56'h01_0060_A5A55A5A), 8);
      repeat (12) @(negedge clk);
      check_status("crst_after", 4'b0000, 16'd0, 16'd1);
      $display("seq soft_reset: flags=%b err=%0d pkt=%0d", flags, err_cnt, pkt_cnt);

      // Hard reset while a write is outstanding.
      soft_reset();
      send_pkt(good(56'h01_0070_00000001) ^ 72'h100, 8);
      ack_dly = -1;
      sb.push_back('{addr: 16'h0070, data: 32'h00000002});
      send_pkt(good(56'h01_0070_00000002), 8);
      check("pre_rst_wr", 32'(bus.reg_wr_o), 32'd1);
      check("pre_rst_err", 32'(err_cnt), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_wr", 32'(bus.reg_wr_o), 32'd0);
      check("async_rst_addr", 32'(bus.reg_addr_o), 32'd0);
      check("async_rst_wdata", bus.reg_wdata_o, 32'd0);
      check_status("async_rst", 4'b0000, 16'd0, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      $display("seq hard_reset: wr=%0d flags=%b err=%0d pkt=%0d", bus.reg_wr_o, flags, err_cnt, pkt_cnt);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
